// File: rtl/apb4_mem_slave.sv
// apb4_mem_slave: APB4 word RAM with byte strobes, programmable wait states and PSLVERR
module apb4_mem_slave #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic                    pclk,
   input  logic                    prst_n,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int AL = $clog2(NB);
   localparam int IW = $clog2(DEPTH);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t state, state_nx;
   logic [3:0] cnt;
   logic err, wr, illegal, setup, done;
   logic [IW-1:0] idx;
   logic [ADDR_WIDTH-1:0] widx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   assign widx    = paddr >> AL;
   assign illegal = ({1'b0, widx} >= (ADDR_WIDTH+1)'(DEPTH)) || (|(paddr & ADDR_WIDTH'(NB-1)));
   assign setup   = (state == IDLE) && psel && !penable;
   assign pready  = (state == ACCESS) && (cnt == 4'd0);
   assign done    = pready && psel && penable;
   assign pslverr = err && pready;
   always_comb begin
      state_nx = state;
      state_nx = setup ? ACCESS : ((state == ACCESS) && (!psel || done)) ? IDLE : state;
   end
   always_ff @(posedge pclk)
      state <= !prst_n ? IDLE : state_nx;
   // Address and read data are captured at setup; write lanes land on the completion edge.
   always_ff @(posedge pclk) begin
      if (!prst_n) begin
         cnt    <= 4'd0;
         err    <= 1'b0;
         wr     <= 1'b0;
         idx    <= '0;
         prdata <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (setup) begin
            cnt    <= 4'(WAIT_STATES);
            err    <= illegal;
            wr     <= pwrite;
            idx    <= widx[IW-1:0];
            prdata <= (pwrite || illegal) ? '0 : mem[widx[IW-1:0]];
         end else if ((state == ACCESS) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (done && wr && !err)
            for (int i = 0; i < NB; i++)
               if (pstrb[i]) mem[idx][i*8 +: 8] <= pwdata[i*8 +: 8];
      end
   end
endmodule

// File: tb/tb_apb4_mem_slave.sv
// tb_apb4_mem_slave: random and directed APB transfers on a zero-wait and a three-wait slave
module tb_apb4_mem_slave;
   logic pclk = 1'b0, prst_n = 1'b0;
   logic psel[2], penable[2], pwrite[2], pready[2], pslverr[2];
   logic [9:0] paddr[2];
   logic [31:0] pwdata[2], prdata[2];
   logic [3:0] pstrb[2];
   logic [31:0] ref_mem[2][64];
   logic [31:0] rd;
   int errors = 0, checks = 0;
   always #5 pclk = ~pclk;
   apb4_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u0 (
      .pclk(pclk), .prst_n(prst_n), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
      .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .pready(pready[0]),
      .prdata(prdata[0]), .pslverr(pslverr[0]));
   apb4_mem_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u3 (
      .pclk(pclk), .prst_n(prst_n), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
      .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .pready(pready[1]),
      .prdata(prdata[1]), .pslverr(pslverr[1]));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 64; i++) ref_mem[d][i] = 32'h0;
   endtask
   task automatic xfer(input int d, input bit w, input logic [9:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] r);
      bit ill;
      int ws, n;
      logic [31:0] exp;
      ill = (a >= 10'd256) || (a[1:0] != 2'd0);
      ws  = (d == 1) ? 3 : 0;
      n   = 0;
      exp = (w || ill) ? 32'h0 : ref_mem[d][a[7:2]];
      @(posedge pclk); #1;
      psel[1-d] = 1'b0; penable[1-d] = 1'b0;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = w; paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
      check("setup_ready", 32'(pready[d]), 32'h0);
      @(posedge pclk); #1;
      penable[d] = 1'b1;
      while (!pready[d] && n < 20) begin
         @(posedge pclk); #1;
         n++;
      end
      check("wait_cycles", n, ws);
      check("pslverr", 32'(pslverr[d]), 32'(ill));
      r = prdata[d];
      if (!w) check("prdata", prdata[d], exp);
      if (w && !ill)
         for (int i = 0; i < 4; i++)
            if (st[i]) ref_mem[d][a[7:2]][i*8 +: 8] = wd[i*8 +: 8];
   endtask
   task automatic idle(input int d);
      @(posedge pclk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask
   initial begin
      for (int d = 0; d < 2; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
         paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      end
      clear_model();
      repeat (2) @(posedge pclk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_pready", 32'(pready[d]), 32'h0);
         check("rst_prdata", prdata[d], 32'h0);
         check("rst_pslverr", 32'(pslverr[d]), 32'h0);
      end
      prst_n = 1'b1;
      xfer(0, 0, 10'h030, 0, 4'h0, rd);
      xfer(1, 0, 10'h03C, 0, 4'h0, rd);
      xfer(0, 1, 10'h010, 32'hDEADBEEF, 4'hF, rd);
      xfer(0, 0, 10'h010, 0, 4'h0, rd);
      check("ws0_data", rd, 32'hDEADBEEF);
      xfer(0, 1, 10'h004, 32'h11223344, 4'hF, rd);
      xfer(0, 1, 10'h004, 32'hAABBCCDD, 4'b0101, rd);
      xfer(0, 0, 10'h004, 0, 4'h0, rd);
      check("strobe_merge", rd, 32'h11BB33DD);
      xfer(1, 1, 10'h008, 32'hCAFEF00D, 4'hF, rd);
      xfer(1, 0, 10'h008, 0, 4'h0, rd);
      xfer(1, 0, 10'h008, 0, 4'h0, rd);
      check("ws3_data", rd, 32'hCAFEF00D);
      idle(1);
      xfer(0, 1, 10'h100, 32'h55555555, 4'hF, rd);
      xfer(0, 1, 10'h002, 32'h66666666, 4'hF, rd);
      xfer(0, 0, 10'h100, 0, 4'h0, rd);
      xfer(0, 0, 10'h000, 0, 4'h0, rd);
      check("err_no_write", rd, 32'h0);
      idle(0);
      @(posedge pclk); #1;
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 10'h00C;
      pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
      @(posedge pclk); #1;
      penable[1] = 1'b1;
      check("abort_wait", 32'(pready[1]), 32'h0);
      @(posedge pclk); #1;
      psel[1] = 1'b0; penable[1] = 1'b0;
      xfer(1, 0, 10'h00C, 0, 4'h0, rd);
      check("abort_no_write", rd, 32'h0);
      idle(1);
      @(posedge pclk); #1;
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'h020;
      pwdata[0] = 32'h0BADF00D; pstrb[0] = 4'hF;
      @(posedge pclk); #1;
      penable[0] = 1'b1;
      prst_n = 1'b0;
      @(posedge pclk); #1;
      psel[0] = 1'b0; penable[0] = 1'b0;
      check("midrst_pready", 32'(pready[0]), 32'h0);
      check("midrst_prdata", prdata[0], 32'h0);
      clear_model();
      @(posedge pclk); #1;
      prst_n = 1'b1;
      xfer(0, 0, 10'h020, 0, 4'h0, rd);
      check("midrst_word", rd, 32'h0);
      xfer(1, 0, 10'h008, 0, 4'h0, rd);
      for (int k = 0; k < 300; k++) begin
         int d;
         logic [9:0] a;
         d = $urandom_range(0, 1);
         a = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15) * 4);
         xfer(d, 1'($urandom), a, $urandom, 4'($urandom), rd);
         if ($urandom_range(0, 3) == 0) idle(d);
      end
      idle(0);
      idle(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
